// File: rtl/lynxTypes.sv
// Shared types and constants for the AXI4SR send path.
package lynxTypes;

   localparam int AXI_DATA_BITS   = 512;
   localparam int PID_BITS        = 6;
   localparam int FRAMER_LEN_BITS = 28;
   localparam int KEEP_BITS       = AXI_DATA_BITS / 8;
   localparam int REM_BITS        = $clog2(KEEP_BITS);

   typedef enum logic {
      ST_IDLE,
      ST_XFER
   } framer_state_t;

   // Last-beat byte enables: a zero remainder means the final beat is full.
   function automatic logic [KEEP_BITS-1:0] keep_from_rem(input logic [REM_BITS-1:0] rem);
      logic [KEEP_BITS-1:0] keep;
      for (int i = 0; i < KEEP_BITS; i++) begin
         keep[i] = (rem == '0) || (i < int'(rem));
      end
      return keep;
   endfunction

endpackage

// File: rtl/axisr_framer_skid.sv
// Two-entry registered output buffer (main + spare) for the framed stream.
// Outputs come straight from the main entry; in_ready_o is the spare-empty flop.
module axisr_framer_skid #(
   parameter int W = 8
) (
   input  logic         aclk,
   input  logic         aresetn,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o,
   output logic         busy_o
);

   logic         main_v_q, main_v_d;
   logic         spare_v_q, spare_v_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] spare_q, spare_d;

   // Refill main from spare first so beat order is preserved; park in spare only on a stall.
   always_comb begin
      main_v_d  = main_v_q;
      main_d    = main_q;
      spare_v_d = spare_v_q;
      spare_d   = spare_q;
      if (!main_v_q || out_ready_i) begin
         if (spare_v_q) begin
            main_d    = spare_q;
            main_v_d  = 1'b1;
            spare_v_d = 1'b0;
         end else begin
            main_v_d = in_valid_i;
            if (in_valid_i) main_d = in_data_i;
         end
      end else if (in_valid_i && !spare_v_q) begin
         spare_d   = in_data_i;
         spare_v_d = 1'b1;
      end
   end

   // Buffer registers; reset empties both entries so tvalid drops at once.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         main_v_q  <= 1'b0;
         spare_v_q <= 1'b0;
         main_q    <= '0;
         spare_q   <= '0;
      end else begin
         main_v_q  <= main_v_d;
         spare_v_q <= spare_v_d;
         main_q    <= main_d;
         spare_q   <= spare_d;
      end
   end

   assign in_ready_o  = ~spare_v_q;
   assign out_valid_o = main_v_q;
   assign out_data_o  = main_q;
   assign busy_o      = main_v_q | spare_v_q;

endmodule

// File: rtl/axisr_pkt_framer.sv
// Transmit framer: turns a (pid, byte length) command plus raw payload beats
// into an AXI4SR packet with tid, tkeep and tlast.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for a command; zero-length commands are dropped here
//   ST_XFER | forwarding payload beats until beats_left reaches zero
module axisr_pkt_framer
   import lynxTypes::*;
#(
   parameter int DATA_BITS = AXI_DATA_BITS,
   parameter int LEN_BITS  = FRAMER_LEN_BITS,
   parameter int CNT_BITS  = 32
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [PID_BITS-1:0]    cmd_pid,
   input  logic [LEN_BITS-1:0]    cmd_len,
   input  logic                   s_data_tvalid,
   output logic                   s_data_tready,
   input  logic [DATA_BITS-1:0]   s_data_tdata,
   output logic [DATA_BITS-1:0]   m_axis_tdata,
   output logic [DATA_BITS/8-1:0] m_axis_tkeep,
   output logic [PID_BITS-1:0]    m_axis_tid,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [CNT_BITS-1:0]    stat_pkts,
   output logic                   busy
);

   localparam int BYTES = DATA_BITS / 8;
   localparam int RB    = $clog2(BYTES);
   localparam int SW    = DATA_BITS + BYTES + PID_BITS + 1;

   framer_state_t       state_q, state_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic [PID_BITS-1:0] pid_q, pid_d;
   logic [LEN_BITS-1:0] beats_q, beats_d;
   logic [RB-1:0]       rem_q, rem_d;
   logic [CNT_BITS-1:0] stat_q, stat_d;

   logic                beat_valid;
   logic                beat_last;
   logic [BYTES-1:0]    beat_keep;
   logic                skid_ready;
   logic                skid_busy;
   logic [SW-1:0]       skid_out;

   assign s_data_tready = (state_q == ST_XFER) && skid_ready;

   // Command latch, beat countdown, last-beat tkeep and packet statistics.
   always_comb begin
      state_d    = state_q;
      pid_d      = pid_q;
      beats_d    = beats_q;
      rem_d      = rem_q;
      stat_d     = stat_q;
      beat_valid = 1'b0;
      beat_last  = 1'b0;
      beat_keep  = '1;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               pid_d   = cmd_pid;
               rem_d   = cmd_len[RB-1:0];
               beats_d = (cmd_len >> RB) + LEN_BITS'(cmd_len[RB-1:0] != '0);
               if (cmd_len != '0) state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            if (s_data_tvalid && s_data_tready) begin
               beat_valid = 1'b1;
               beats_d    = beats_q - LEN_BITS'(1);
               if (beats_q == LEN_BITS'(1)) begin
                  beat_last = 1'b1;
                  beat_keep = keep_from_rem(rem_q);
                  state_d   = ST_IDLE;
                  stat_d    = stat_q + CNT_BITS'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Registered so cmd_ready stays low through reset and rises one cycle later.
      cmd_ready_d = (state_d == ST_IDLE);
   end

   // FSM and command/statistics registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b0;
         pid_q       <= '0;
         beats_q     <= '0;
         rem_q       <= '0;
         stat_q      <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         pid_q       <= pid_d;
         beats_q     <= beats_d;
         rem_q       <= rem_d;
         stat_q      <= stat_d;
      end
   end

   axisr_framer_skid #(.W(SW)) u_skid (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .in_valid_i  (beat_valid),
      .in_ready_o  (skid_ready),
      .in_data_i   ({s_data_tdata, beat_keep, pid_q, beat_last}),
      .out_valid_o (m_axis_tvalid),
      .out_ready_i (m_axis_tready),
      .out_data_o  (skid_out),
      .busy_o      (skid_busy)
   );

   assign {m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tlast} = skid_out;

   assign cmd_ready = cmd_ready_q;
   assign stat_pkts = stat_q;
   assign busy      = (state_q == ST_XFER) || skid_busy;

endmodule

// File: tb/tb_axisr_pkt_framer.sv
// Bench for axisr_pkt_framer: a packet-level model (queue of expected beats
// built from each accepted command) checked on every output handshake.
module tb_axisr_pkt_framer;
   import lynxTypes::*;

   localparam int DB = 512;
   localparam int KB = 64;
   localparam int LB = 28;
   localparam int CB = 32;

   logic                aclk = 1'b0;
   logic                aresetn = 1'b0;
   logic                cmd_valid;
   logic                cmd_ready;
   logic [PID_BITS-1:0] cmd_pid;
   logic [LB-1:0]       cmd_len;
   logic                s_data_tvalid;
   logic                s_data_tready;
   logic [DB-1:0]       s_data_tdata;
   logic [DB-1:0]       m_axis_tdata;
   logic [KB-1:0]       m_axis_tkeep;
   logic [PID_BITS-1:0] m_axis_tid;
   logic                m_axis_tlast;
   logic                m_axis_tvalid;
   logic                m_axis_tready = 1'b1;
   logic [CB-1:0]       stat_pkts;
   logic                busy;

   axisr_pkt_framer dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_pid       (cmd_pid),
      .cmd_len       (cmd_len),
      .s_data_tvalid (s_data_tvalid),
      .s_data_tready (s_data_tready),
      .s_data_tdata  (s_data_tdata),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tid    (m_axis_tid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .stat_pkts     (stat_pkts),
      .busy          (busy)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [DB-1:0]       data;
      logic [KB-1:0]       keep;
      logic [PID_BITS-1:0] tid;
      logic                last;
   } beat_t;

   beat_t exp_q[$];
   int    n_tests = 0;
   int    n_fail = 0;
   int    dcount = 0;
   int    exp_total = 0;
   int    model_pkts = 0;
   int    cyc = 0;
   int    out_cnt = 0;
   int    n_last = 0;
   int    first_cyc = 0;
   int    last_cyc = 0;
   logic [KB-1:0]       last_keep = '0;
   logic [PID_BITS-1:0] last_tid = '0;
   logic                last_tlast = 1'b0;
   bit    data_always = 1'b1;
   bit    rdy_random = 1'b0;

   function automatic logic [DB-1:0] pattern(input int k);
      logic [31:0] w;
      w = 32'(k) * 32'h9E3779B1 + 32'h0000_1234;
      return {16{w}};
   endfunction

   // Byte enables for a last beat carrying 'bytes' valid bytes (1..64).
   function automatic logic [KB-1:0] model_keep(input int bytes);
      logic [KB:0] m;
      m = (65'd1 << bytes) - 65'd1;
      return m[KB-1:0];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge aclk) cyc <= cyc + 1;

   // Payload source: beat k always carries pattern(k).
   initial begin
      s_data_tvalid = 1'b0;
      s_data_tdata  = '0;
      forever begin
         @(posedge aclk);
         #1;
         s_data_tvalid = data_always ? 1'b1 : ($urandom_range(0, 3) != 0);
         s_data_tdata  = pattern(dcount);
      end
   end

   initial begin
      forever begin
         @(posedge aclk);
         #1;
         m_axis_tready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor/compare: handshakes that will occur at the coming posedge.
   always @(negedge aclk) begin : mon
      int    n;
      beat_t b;
      bit    stall_prev;
      beat_t prev;
      if (!aresetn) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            n_tests++;
            if (!m_axis_tvalid || m_axis_tdata !== prev.data || m_axis_tkeep !== prev.keep ||
                m_axis_tid !== prev.tid || m_axis_tlast !== prev.last) begin
               n_fail++;
               $display("FAIL stall_hold: valid=%0b tid=%0h last=%0b changed while stalled (tid was %0h)",
                        m_axis_tvalid, m_axis_tid, m_axis_tlast, prev.tid);
            end
         end
         if (m_axis_tvalid && m_axis_tready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_beat: tid=%0h last=%0b with no beat expected", m_axis_tid, m_axis_tlast);
            end else begin
               b = exp_q.pop_front();
               if (m_axis_tdata !== b.data || m_axis_tkeep !== b.keep || m_axis_tid !== b.tid ||
                   m_axis_tlast !== b.last) begin
                  n_fail++;
                  $display("FAIL beat: got tid=%0h keep=%h last=%0b data=%h expected tid=%0h keep=%h last=%0b",
                           m_axis_tid, m_axis_tkeep, m_axis_tlast, m_axis_tdata[63:0], b.tid, b.keep, b.last);
               end
            end
            if (out_cnt == 0) first_cyc = cyc;
            last_cyc   = cyc;
            out_cnt++;
            if (m_axis_tlast) n_last++;
            last_keep  = m_axis_tkeep;
            last_tid   = m_axis_tid;
            last_tlast = m_axis_tlast;
         end
         stall_prev = m_axis_tvalid && !m_axis_tready;
         prev.data  = m_axis_tdata;
         prev.keep  = m_axis_tkeep;
         prev.tid   = m_axis_tid;
         prev.last  = m_axis_tlast;
         if (s_data_tvalid && s_data_tready) begin
            n_tests++;
            if (dcount >= exp_total) begin
               n_fail++;
               $display("FAIL data_consume: consumed beat %0d but only %0d commanded", dcount, exp_total);
            end
            dcount++;
         end
         if (cmd_valid && cmd_ready) begin
            n = (int'(cmd_len) + KB - 1) / KB;
            for (int i = 0; i < n; i++) begin
               b.data = pattern(exp_total);
               b.keep = (i == n - 1) ? model_keep(int'(cmd_len) - i * KB) : '1;
               b.tid  = cmd_pid;
               b.last = (i == n - 1);
               exp_q.push_back(b);
               exp_total++;
            end
            if (n > 0) model_pkts++;
         end
      end
   end

   task automatic send_cmd(input int pid, input int len);
      int t;
      t = 0;
      @(posedge aclk);
      #1;
      cmd_valid = 1'b1;
      cmd_pid   = PID_BITS'(pid);
      cmd_len   = LB'(len);
      do begin
         @(negedge aclk);
         t++;
      end while (!cmd_ready && t < 2000);
      if (!cmd_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL cmd_accept: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, t);
      end
      @(posedge aclk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      do begin
         @(negedge aclk);
         t++;
      end while ((busy || exp_q.size() != 0) && t < 5000);
      repeat (2) @(negedge aclk);
      check("drain", {63'd0, busy || (exp_q.size() != 0)}, 64'd0);
   endtask

   initial begin
      cmd_valid = 1'b0;
      cmd_pid   = '0;
      cmd_len   = '0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      check("rst_s_tready", 64'(s_data_tready), 64'd0);
      check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_tkeep", m_axis_tkeep, 64'd0);
      check("rst_tid_tlast", {57'd0, m_axis_tid, m_axis_tlast}, 64'd0);
      check("rst_stat", 64'(stat_pkts), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      #2 aresetn = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

      // 4 full beats, back-to-back on the output
      out_cnt = 0;
      send_cmd(3, 256);
      wait_drain();
      check("t1_beats", 64'(out_cnt), 64'd4);
      check("t1_span", 64'(last_cyc - first_cyc), 64'd3);
      check("t1_tid", 64'(last_tid), 64'd3);
      check("t1_stat", 64'(stat_pkts), 64'd1);

      // partial last beat: 36 bytes
      out_cnt = 0;
      send_cmd(5, 100);
      wait_drain();
      check("t2_beats", 64'(out_cnt), 64'd2);
      check("t2_last_keep", last_keep, 64'h0000000F_FFFFFFFF);
      check("t2_stat", 64'(stat_pkts), 64'd2);

      // zero-length command is swallowed
      out_cnt = 0;
      send_cmd(2, 0);
      send_cmd(1, 64);
      wait_drain();
      check("t3_beats", 64'(out_cnt), 64'd1);
      check("t3_tid", 64'(last_tid), 64'd1);
      check("t3_keep", last_keep, 64'hFFFFFFFF_FFFFFFFF);
      check("t3_stat", 64'(stat_pkts), 64'd3);

      // 10 beats under random backpressure and bursty source
      rdy_random  = 1'b1;
      data_always = 1'b0;
      out_cnt = 0;
      send_cmd(7, 640);
      wait_drain();
      check("t4_beats", 64'(out_cnt), 64'd10);
      check("t4_stat", 64'(stat_pkts), 64'd4);

      // two back-to-back 2-beat packets
      rdy_random  = 1'b0;
      data_always = 1'b1;
      out_cnt = 0;
      n_last  = 0;
      send_cmd(4, 128);
      send_cmd(6, 128);
      wait_drain();
      check("t5_beats", 64'(out_cnt), 64'd4);
      check("t5_lasts", 64'(n_last), 64'd2);
      check("t5_stat", 64'(stat_pkts), 64'd6);

      // random commands, random backpressure
      rdy_random  = 1'b1;
      data_always = 1'b0;
      for (int i = 0; i < 12; i++) begin
         send_cmd(int'($urandom_range(0, 63)), int'($urandom_range(0, 400)));
      end
      wait_drain();
      check("rand_stat", 64'(stat_pkts), 64'(model_pkts));

      // reset in the middle of a 5-beat packet
      rdy_random  = 1'b0;
      data_always = 1'b1;
      out_cnt = 0;
      send_cmd(9, 320);
      begin
         int t;
         t = 0;
         while (out_cnt < 2 && t < 1000) begin
            @(negedge aclk);
            t++;
         end
      end
      check("t6_pre_beats", 64'(out_cnt), 64'd2);
      @(posedge aclk);
      #3 aresetn = 1'b0;
      #1;
      check("t6_tvalid_async", 64'(m_axis_tvalid), 64'd0);
      check("t6_stat_async", 64'(stat_pkts), 64'd0);
      check("t6_busy_async", 64'(busy), 64'd0);
      exp_q.delete();
      dcount     = 0;
      exp_total  = 0;
      model_pkts = 0;
      repeat (2) @(posedge aclk);
      #3 aresetn = 1'b1;
      out_cnt = 0;
      send_cmd(1, 64);
      wait_drain();
      check("t6_beats", 64'(out_cnt), 64'd1);
      check("t6_tlast", 64'(last_tlast), 64'd1);
      check("t6_tid", 64'(last_tid), 64'd1);
      check("t6_stat", 64'(stat_pkts), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
